// File: rtl/spw_jtag_pkg.sv
// Shared definitions for the SpaceWire node JTAG TAP: state encodings, opcodes and ID defaults.
package spw_jtag_pkg;

    // 1149.1 customary 4-bit state encodings, exposed on tap_state for debug.
    typedef enum logic [3:0] {
        EX2_DR = 4'h0,
        EX1_DR = 4'h1,
        SH_DR  = 4'h2,
        PA_DR  = 4'h3,
        SEL_IR = 4'h4,
        UPD_DR = 4'h5,
        CAP_DR = 4'h6,
        SEL_DR = 4'h7,
        EX2_IR = 4'h8,
        EX1_IR = 4'h9,
        SH_IR  = 4'hA,
        PA_IR  = 4'hB,
        RTI    = 4'hC,
        UPD_IR = 4'hD,
        CAP_IR = 4'hE,
        TLR    = 4'hF
    } tap_state_e;

    localparam int unsigned OP_IDCODE   = 1;
    localparam int unsigned OP_SPW_CTRL = 2;

    localparam logic [31:0] IDCODE_DEFAULT = 32'h1000_0FFF;

    // All-ones opcode of the given IR width.
    function automatic logic [31:0] op_bypass(input int unsigned w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/spw_jtag_tap_fsm.sv
// 16-state IEEE 1149.1 TAP controller with decoded capture/shift/update flags.
module spw_jtag_tap_fsm
    import spw_jtag_pkg::*;
(
    input  logic       TCK,
    input  logic       TRST,
    input  logic       TMS,
    output logic [3:0] tap_state,
    output logic       st_tlr,
    output logic       cap_ir,
    output logic       sh_ir,
    output logic       upd_ir,
    output logic       cap_dr,
    output logic       sh_dr,
    output logic       upd_dr
);

    tap_state_e state_reg, state_next;

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            state_reg <= TLR;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = TLR;
        case (state_reg)
            TLR:     state_next = TMS ? TLR    : RTI;
            RTI:     state_next = TMS ? SEL_DR : RTI;
            SEL_DR:  state_next = TMS ? SEL_IR : CAP_DR;
            CAP_DR:  state_next = TMS ? EX1_DR : SH_DR;
            SH_DR:   state_next = TMS ? EX1_DR : SH_DR;
            EX1_DR:  state_next = TMS ? UPD_DR : PA_DR;
            PA_DR:   state_next = TMS ? EX2_DR : PA_DR;
            EX2_DR:  state_next = TMS ? UPD_DR : SH_DR;
            UPD_DR:  state_next = TMS ? SEL_DR : RTI;
            SEL_IR:  state_next = TMS ? TLR    : CAP_IR;
            CAP_IR:  state_next = TMS ? EX1_IR : SH_IR;
            SH_IR:   state_next = TMS ? EX1_IR : SH_IR;
            EX1_IR:  state_next = TMS ? UPD_IR : PA_IR;
            PA_IR:   state_next = TMS ? EX2_IR : PA_IR;
            EX2_IR:  state_next = TMS ? UPD_IR : SH_IR;
            UPD_IR:  state_next = TMS ? SEL_DR : RTI;
            default: state_next = TLR;
        endcase
    end

    always_comb begin
        tap_state = state_reg;
        st_tlr    = (state_reg == TLR);
        cap_ir    = (state_reg == CAP_IR);
        sh_ir     = (state_reg == SH_IR);
        upd_ir    = (state_reg == UPD_IR);
        cap_dr    = (state_reg == CAP_DR);
        sh_dr     = (state_reg == SH_DR);
        upd_dr    = (state_reg == UPD_DR);
    end

endmodule

// File: rtl/spw_jtag_tap.sv
// JTAG TAP for the SpaceWire node: IR, BYPASS, optional IDCODE and the SPW_CTRL user register.
// Optional feature macro: SPW_JTAG_IDCODE_EN (IDCODE register present, ir_q resets to IDCODE).
module spw_jtag_tap
    import spw_jtag_pkg::*;
#(
    parameter int          IR_W       = 4,
    parameter int          DR_W       = 32,
    parameter logic [31:0] IDCODE_VAL = IDCODE_DEFAULT
) (
    input  logic            TCK,
    input  logic            TRST,
    input  logic            TMS,
    input  logic            TDI,
    output logic            TDO,
    output logic            TDO_EN,
    input  logic [DR_W-1:0] udr_cap,
    output logic [DR_W-1:0] udr_upd,
    output logic            udr_upd_stb,
    output logic [3:0]      tap_state,
    output logic [IR_W-1:0] ir_q
);

    localparam logic [IR_W-1:0] BYPASS_OP = IR_W'(op_bypass(IR_W));
    localparam logic [IR_W-1:0] SPW_OP    = IR_W'(OP_SPW_CTRL);
`ifdef SPW_JTAG_IDCODE_EN
    localparam logic [IR_W-1:0] IDC_OP    = IR_W'(OP_IDCODE);
    localparam logic [IR_W-1:0] IR_RESET  = IDC_OP;
`else
    localparam logic [IR_W-1:0] IR_RESET  = BYPASS_OP;
`endif

    logic st_tlr, cap_ir, sh_ir, upd_ir, cap_dr, sh_dr, upd_dr;

    spw_jtag_tap_fsm u_fsm (
        .TCK       (TCK),
        .TRST      (TRST),
        .TMS       (TMS),
        .tap_state (tap_state),
        .st_tlr    (st_tlr),
        .cap_ir    (cap_ir),
        .sh_ir     (sh_ir),
        .upd_ir    (upd_ir),
        .cap_dr    (cap_dr),
        .sh_dr     (sh_dr),
        .upd_dr    (upd_dr)
    );

    logic [IR_W-1:0] ir_sr_reg;
    logic            byp_reg;
    logic [DR_W-1:0] udr_sr_reg;
    logic [DR_W-1:0] udr_shift;
    logic            sel_spw;
    logic            tdo_next;

    assign sel_spw = (ir_q == SPW_OP);

    // Shifted SPW_CTRL value; written per bit so DR_W = 1 needs no special slice.
    for (genvar gi = 0; gi < DR_W; gi++) begin : g_udr_shift
        if (gi == DR_W - 1) begin : g_msb
            assign udr_shift[gi] = TDI;
        end else begin : g_low
            assign udr_shift[gi] = udr_sr_reg[gi+1];
        end
    end

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            ir_sr_reg <= '0;
        end else if (st_tlr) begin
            ir_sr_reg <= '0;
        end else if (cap_ir) begin
            ir_sr_reg <= IR_W'(1);
        end else if (sh_ir) begin
            ir_sr_reg <= {TDI, ir_sr_reg[IR_W-1:1]};
        end
    end

    // BYPASS also serves every opcode that has no register of its own.
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            byp_reg <= 1'b0;
        end else if (st_tlr || cap_dr) begin
            byp_reg <= 1'b0;
        end else if (sh_dr) begin
            byp_reg <= TDI;
        end
    end

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            udr_sr_reg <= '0;
        end else if (st_tlr) begin
            udr_sr_reg <= '0;
        end else if (cap_dr && sel_spw) begin
            udr_sr_reg <= udr_cap;
        end else if (sh_dr && sel_spw) begin
            udr_sr_reg <= udr_shift;
        end
    end

`ifdef SPW_JTAG_IDCODE_EN
    logic        sel_idc;
    logic [31:0] idc_sr_reg;

    assign sel_idc = (ir_q == IDC_OP);

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            idc_sr_reg <= '0;
        end else if (st_tlr) begin
            idc_sr_reg <= '0;
        end else if (cap_dr && sel_idc) begin
            idc_sr_reg <= IDCODE_VAL;
        end else if (sh_dr && sel_idc) begin
            idc_sr_reg <= {TDI, idc_sr_reg[31:1]};
        end
    end
`endif

    always_comb begin
        tdo_next = 1'b0;
        if (sh_ir) begin
            tdo_next = ir_sr_reg[0];
        end else if (sh_dr) begin
            tdo_next = byp_reg;
            if (sel_spw) begin
                tdo_next = udr_sr_reg[0];
            end
`ifdef SPW_JTAG_IDCODE_EN
            if (sel_idc) begin
                tdo_next = idc_sr_reg[0];
            end
`endif
        end
    end

    // Falling-edge half: TDO launch and the update-stage registers.
    always_ff @(negedge TCK or posedge TRST) begin
        if (TRST) begin
            TDO         <= 1'b0;
            TDO_EN      <= 1'b0;
            ir_q        <= IR_RESET;
            udr_upd     <= '0;
            udr_upd_stb <= 1'b0;
        end else begin
            TDO         <= tdo_next;
            TDO_EN      <= sh_ir || sh_dr;
            udr_upd_stb <= 1'b0;
            if (st_tlr) begin
                ir_q    <= IR_RESET;
                udr_upd <= '0;
            end else begin
                if (upd_ir) begin
                    ir_q <= ir_sr_reg;
                end
                if (upd_dr && sel_spw) begin
                    udr_upd     <= udr_sr_reg;
                    udr_upd_stb <= 1'b1;
                end
            end
        end
    end

endmodule
